// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for nibble_serial_adder
// Optional ovf member present only when OVF_FLAG_EN is defined.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef OVF_FLAG_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder built from one 4-bit CLA used a nibble per cycle
// Define OVF_FLAG_EN to add the registered signed-overflow output.
module cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int NNIB  = WIDTH / 4;
  localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic [3:0]         nib_sum;
  logic               nib_c;
  logic               last;
  logic               accept;
  logic [WIDTH+3:0]   sum_cat;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (cnt == CNT_W'(NNIB - 1));

  cla_adder u_cla (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .s    (nib_sum),
    .cout (nib_c)
  );

  // New nibble enters at the top so after NNIB passes nibble 0 lands at the bottom.
  assign sum_cat = {nib_sum, sum_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last)         state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_r <= sum_cat[WIDTH+3:4];
          carry <= nib_c;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            cout_r <= nib_c;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OVF_FLAG_EN
  logic a_msb;
  logic b_msb;
  logic ovf_r;

  assign bus.ovf = ovf_r;

  // On the last pass nib_sum[3] is the final sum MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
      if ((state == RUN) && last) begin
        ovf_r <= (a_msb == b_msb) && (nib_sum[3] != a_msb);
      end
    end
  end
`endif

endmodule
